dsp_terminal_counter: RTL and testbench

Single-clock terminal-count timer that counts enabled clock cycles and flags when a programmed count is reached. It measures fixed sampling windows (e.g. a 1 s trigger-rate window of 375,000,000 cycles at 375 MHz) in the L1 trigger path. It can halt at the terminal count or wrap and repeat. The terminal value is either a fixed parameter or a runtime input.

---
 rtl/dsp_tc_pkg.sv | 5 +
 rtl/dsp_terminal_counter.sv | 69 ++++++
 tb/tb_dsp_terminal_counter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dsp_tc_pkg.sv
// Shared width and type for the terminal-count timer.
package dsp_tc_pkg;
    localparam int CNT_W = 48;
    typedef logic [CNT_W-1:0] tcount_t;
endpackage

// File: rtl/dsp_terminal_counter.sv
// Terminal-count timer: counts enabled cycles, pulses on reaching TC, halts or wraps.
// Optional count_o output port is enabled by defining DSP_TCOUNT_COUNT_OUT_EN.
module dsp_terminal_counter
    import dsp_tc_pkg::*;
#(
    parameter string   FIXED_TCOUNT       = "TRUE",
    parameter tcount_t FIXED_TCOUNT_VALUE = tcount_t'(375000000),
    parameter string   HALT_AT_TCOUNT     = "TRUE"
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    count_i,
    input  tcount_t tcount_i,
`ifdef DSP_TCOUNT_COUNT_OUT_EN
    output logic    tcount_reached_o,
    output tcount_t count_o
`else
    output logic    tcount_reached_o
`endif
);

    localparam bit USE_FIXED = (FIXED_TCOUNT == "TRUE");
    localparam bit HALT_EN   = (HALT_AT_TCOUNT == "TRUE");

    if (USE_FIXED && (FIXED_TCOUNT_VALUE == '0)) begin : g_bad_tcount
        $error("dsp_terminal_counter: FIXED_TCOUNT_VALUE must be non-zero");
    end

    tcount_t r_cnt;
    logic    r_halted;
    logic    r_reached;

    tcount_t w_tc;
    tcount_t w_cnt_inc;
    logic    w_active;
    logic    w_terminal;

    assign w_tc      = USE_FIXED ? FIXED_TCOUNT_VALUE : tcount_i;
    assign w_cnt_inc = r_cnt + tcount_t'(1);
    assign w_active  = count_i && !r_halted;
    // A zero runtime TC must not match when the adder rolls over at 2^48.
    assign w_terminal = w_active && (w_tc != '0) && (w_cnt_inc == w_tc);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt     <= '0;
            r_halted  <= 1'b0;
            r_reached <= 1'b0;
        end else begin
            r_reached <= w_terminal;
            if (w_terminal) begin
                if (HALT_EN) begin
                    r_cnt    <= w_tc;
                    r_halted <= 1'b1;
                end else begin
                    r_cnt <= '0;
                end
            end else if (w_active) begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    assign tcount_reached_o = r_reached;
`ifdef DSP_TCOUNT_COUNT_OUT_EN
    assign count_o = r_cnt;
`endif

endmodule

// File: tb/tb_dsp_terminal_counter.sv
// Self-checking bench: halt, wrap and runtime-TC instances against an event-count model.
module tb_dsp_terminal_counter;
    import dsp_tc_pkg::*;

    logic    clk = 1'b0;
    logic    rst_i = 1'b1;
    logic    count_i = 1'b0;
    tcount_t tcount_i = tcount_t'(3);
    logic    tr_h, tr_w, tr_r;
`ifdef DSP_TCOUNT_COUNT_OUT_EN
    tcount_t cnt_h, cnt_w, cnt_r;
`endif

    int errors = 0;
    int checks = 0;

    // events since last reset, per instance; expected behaviour is derived from these
    longint e_h, e_w, e_r;
    longint tc_r;
    int     n_h, n_w, n_r;

    always #5 clk = ~clk;

    dsp_terminal_counter #(.FIXED_TCOUNT("TRUE"), .FIXED_TCOUNT_VALUE(tcount_t'(5)),
                           .HALT_AT_TCOUNT("TRUE")) u_halt (
        .clk_i(clk), .rst_i(rst_i), .count_i(count_i), .tcount_i(tcount_t'(0)),
`ifdef DSP_TCOUNT_COUNT_OUT_EN
        .count_o(cnt_h),
`endif
        .tcount_reached_o(tr_h));

    dsp_terminal_counter #(.FIXED_TCOUNT("TRUE"), .FIXED_TCOUNT_VALUE(tcount_t'(5)),
                           .HALT_AT_TCOUNT("FALSE")) u_wrap (
        .clk_i(clk), .rst_i(rst_i), .count_i(count_i), .tcount_i(tcount_t'(7)),
`ifdef DSP_TCOUNT_COUNT_OUT_EN
        .count_o(cnt_w),
`endif
        .tcount_reached_o(tr_w));

    dsp_terminal_counter #(.FIXED_TCOUNT("FALSE"), .FIXED_TCOUNT_VALUE(tcount_t'(5)),
                           .HALT_AT_TCOUNT("FALSE")) u_rt (
        .clk_i(clk), .rst_i(rst_i), .count_i(count_i), .tcount_i(tcount_i),
`ifdef DSP_TCOUNT_COUNT_OUT_EN
        .count_o(cnt_r),
`endif
        .tcount_reached_o(tr_r));

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One clock: apply inputs, advance the model, compare 1 time unit after the edge.
    task automatic step(input logic rst, input logic cen);
        logic ph, pw, pr;
        rst_i   = rst;
        count_i = cen;
        @(posedge clk);
        ph = 1'b0; pw = 1'b0; pr = 1'b0;
        if (rst) begin
            e_h = 0; e_w = 0; e_r = 0;
        end else if (cen) begin
            ph  = (e_h == 4);
            e_h = e_h + 1;
            e_w = e_w + 1;
            pw  = (e_w % 5 == 0);
            e_r = e_r + 1;
            pr  = (tc_r != 0) && (e_r % tc_r == 0);
        end
        #1;
        chk("pulse_halt", longint'(tr_h), longint'(ph));
        chk("pulse_wrap", longint'(tr_w), longint'(pw));
        chk("pulse_rt",   longint'(tr_r), longint'(pr));
`ifdef DSP_TCOUNT_COUNT_OUT_EN
        chk("count_halt", longint'(cnt_h), (e_h < 5) ? e_h : 64'd5);
        chk("count_wrap", longint'(cnt_w), e_w % 5);
        chk("count_rt",   longint'(cnt_r), (tc_r == 0) ? e_r : e_r % tc_r);
`endif
        if (tr_h) n_h++;
        if (tr_w) n_w++;
        if (tr_r) n_r++;
    endtask

    task automatic do_reset(input longint tc);
        tc_r     = tc;
        tcount_i = tcount_t'(tc);
        step(1'b1, 1'b0);
        n_h = 0; n_w = 0; n_r = 0;
    endtask

    initial begin
        e_h = 0; e_w = 0; e_r = 0; tc_r = 3;
        n_h = 0; n_w = 0; n_r = 0;

        // reset state
        do_reset(3);
        chk("reset_pulse_halt", longint'(tr_h), 0);

        // 20 continuous counts: halt fires once, wrap fires on 5/10/15/20, runtime TC=3 six times
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
        chk("halt_pulse_total", n_h, 1);
        chk("wrap_pulse_total", n_w, 4);
        chk("rt3_pulse_total",  n_r, 6);

        // gated enable 1,0,1,0...: 5th high sample on edge 9
        do_reset(4);
        for (int i = 0; i < 9; i++) step(1'b0, (i % 2) == 0);
        chk("gated_halt_edge9", longint'(tr_h), 1);
        step(1'b0, 1'b0);
        chk("gated_single_pulse", n_h, 1);

        // reset collides with the terminal edge, then restart
        do_reset(5);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("collision_no_pulse", longint'(tr_h), 0);
        n_h = 0; n_w = 0; n_r = 0;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        chk("restart_pulse", longint'(tr_h), 1);
        chk("restart_pulse_rt", longint'(tr_r), 1);

        // runtime TC of zero never fires
        do_reset(0);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1);
        chk("rt_zero_no_pulse", n_r, 0);

        // runtime TC of one pulses on every counting edge
        do_reset(1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
        chk("rt_one_pulses", n_r, 6);

        // random enables, occasional resets with a fresh runtime TC
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0)
                do_reset(longint'($urandom_range(0, 9)));
            else
                step(1'b0, $urandom_range(0, 9) < 7);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
